// File: rtl/mod_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_cnt_pkg
// Brief    : Shared direction constants and modulus legality check for the
//            modulo-N counter family.
// Revision : 1.0
// ============================================================================
package mod_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int MOD_CNT_MAX_MODULUS = 65536;

    function automatic bit mod_cnt_legal(input int modulus);
        return (modulus >= 2) && (modulus <= MOD_CNT_MAX_MODULUS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_cnt_next.sv
`default_nettype none
// ============================================================================
// Module   : mod_cnt_next
// Brief    : Combinational next-state, wrap, load-error and terminal-count
//            logic. MOD_N_COUNTER_SATURATE_EN selects saturating steps.
// Revision : 1.0
// ============================================================================
module mod_cnt_next
    import mod_cnt_pkg::*;
#(
    parameter int MODULUS = 1000,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up_dn,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_next,
    output logic             wrap_next,
    output logic             load_err_next,
    output logic             tc
);

    localparam logic [WIDTH:0] c_mod = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_at_max;
    logic           w_at_zero;
    logic           w_above_max;
    logic           w_up_over;
    logic           w_borrow;
    logic           w_load_ok;

    // Steps are one bit wider than the count so the carry/borrow is visible.
    assign w_cnt_ext   = {1'b0, cnt};
    assign w_inc       = w_cnt_ext + c_one;
    assign w_dec       = w_cnt_ext - c_one;
    assign w_at_max    = (w_cnt_ext == c_max);
    assign w_at_zero   = (cnt == '0);
    assign w_above_max = (w_cnt_ext > c_max);
    assign w_up_over   = (w_inc >= c_mod);
    assign w_borrow    = w_dec[WIDTH];
    assign w_load_ok   = ({1'b0, load_val} < c_mod);

    assign tc = en & ~clr & ~load &
                (((up_dn == CNT_UP) & w_at_max) | ((up_dn == CNT_DN) & w_at_zero));

    always_comb begin
        cnt_next      = cnt;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (clr) begin
            cnt_next = '0;
        end else if (load) begin
            if (w_load_ok) begin
                cnt_next = load_val;
            end else begin
                cnt_next      = '0;
                load_err_next = 1'b1;
            end
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                if (w_up_over) begin
`ifdef MOD_N_COUNTER_SATURATE_EN
                    cnt_next = c_max[WIDTH-1:0];
`else
                    cnt_next = '0;
`endif
                    wrap_next = 1'b1;
                end else begin
                    cnt_next = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_borrow) begin
`ifdef MOD_N_COUNTER_SATURATE_EN
                    cnt_next = '0;
`else
                    cnt_next = c_max[WIDTH-1:0];
`endif
                    wrap_next = 1'b1;
                end else if (w_above_max) begin
                    // Out-of-range state (upset or forced) re-enters at the top.
                    cnt_next = c_max[WIDTH-1:0];
                end else begin
                    cnt_next = w_dec[WIDTH-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_counter
// Brief    : Parametrised modulo-N up/down counter with clear, load, terminal
//            count and registered wrap/load-error pulses.
//            Optional: MOD_N_COUNTER_SATURATE_EN (saturate instead of wrap).
// Revision : 1.0
// ============================================================================
module mod_n_counter
    import mod_cnt_pkg::*;
#(
    parameter int MODULUS = 1000,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (!mod_cnt_legal(MODULUS) || (WIDTH != $clog2(MODULUS))) begin : g_param_check
            $fatal(1, "mod_n_counter: MODULUS must be 2..65536 and WIDTH left at its default");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_load_err;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_wrap_next;
    logic             w_load_err_next;

    mod_cnt_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .cnt           (r_cnt),
        .up_dn         (up_dn),
        .en            (en),
        .clr           (clr),
        .load          (load),
        .load_val      (load_val),
        .cnt_next      (w_cnt_next),
        .wrap_next     (w_wrap_next),
        .load_err_next (w_load_err_next),
        .tc            (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_wrap     <= w_wrap_next;
            r_load_err <= w_load_err_next;
        end
    end

    assign cnt      = r_cnt;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule
`default_nettype wire
